// File: rtl/fpnew_noncomp_writeback.sv
// Writeback stage for the non-computational FP unit: formats results (NaN-box,
// zero-extend, classify mask) into a 2-entry FIFO and accumulates sticky fflags.
module fpnew_noncomp_writeback #(
  parameter int unsigned Width    = 32,
  parameter int unsigned Flen     = 64,
  parameter int unsigned TagWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [Width-1:0]    result_i,
  input  logic [4:0]          status_i,
  input  logic                extension_bit_i,
  input  logic [9:0]          class_mask_i,
  input  logic                is_class_i,
  input  logic [TagWidth-1:0] tag_i,
  input  logic                mask_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [Flen-1:0]     wb_data_o,
  output logic                wb_is_int_o,
  output logic [4:0]          wb_status_o,
  output logic [TagWidth-1:0] wb_tag_o,
  output logic                wb_mask_o,
  output logic [4:0]          fflags_o,
  input  logic                fflags_clr_i,
  output logic                busy_o
);

  logic [Flen-1:0]     fmt_data;
  logic                fmt_is_int;
  logic [4:0]          fmt_status;

  logic [Flen-1:0]     data_q   [2];
  logic                is_int_q [2];
  logic [4:0]          status_q [2];
  logic [TagWidth-1:0] tag_q    [2];
  logic                mask_q   [2];

  logic [1:0]          count_q, count_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [4:0]          fflags_q, fflags_d;

  logic                push, pop;

  // Formatting happens on entry so the output side is a pure register read.
  always_comb begin
    fmt_data   = '0;
    fmt_is_int = 1'b1;
    if (is_class_i) begin
      fmt_data[9:0] = class_mask_i;
    end else if (extension_bit_i) begin
      fmt_data              = '1;
      fmt_data[Width-1:0]   = result_i;
      fmt_is_int            = 1'b0;
    end else begin
      fmt_data[Width-1:0]   = result_i;
    end
    fmt_status = mask_i ? status_i : 5'b0;
  end

  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign busy_o      = (count_q != 2'd0);

  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;

  assign wb_data_o   = data_q[rd_ptr_q];
  assign wb_is_int_o = is_int_q[rd_ptr_q];
  assign wb_status_o = status_q[rd_ptr_q];
  assign wb_tag_o    = tag_q[rd_ptr_q];
  assign wb_mask_o   = mask_q[rd_ptr_q];
  assign fflags_o    = fflags_q;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end

    fflags_d = fflags_clr_i ? 5'b0 : fflags_q;
    if (pop && wb_mask_o && !flush_i) begin
      fflags_d = fflags_d | wb_status_o;
    end

    // Flush wins over any concurrent push/pop; only the clear request survives it.
    if (flush_i) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      fflags_q <= 5'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fflags_q <= fflags_d;
    end
  end

  // Payload storage carries no reset; validity is tracked solely by count_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_q[wr_ptr_q]   <= fmt_data;
      is_int_q[wr_ptr_q] <= fmt_is_int;
      status_q[wr_ptr_q] <= fmt_status;
      tag_q[wr_ptr_q]    <= tag_i;
      mask_q[wr_ptr_q]   <= mask_i;
    end
  end

endmodule

// File: tb/tb_fpnew_noncomp_writeback.sv
// Directed bench for fpnew_noncomp_writeback: formatting, backpressure, fflags, flush, reset.
module tb_fpnew_noncomp_writeback;

  logic        clk_i;
  logic        rst_ni;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] result_i;
  logic [4:0]  status_i;
  logic        extension_bit_i;
  logic [9:0]  class_mask_i;
  logic        is_class_i;
  logic [7:0]  tag_i;
  logic        mask_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] wb_data_o;
  logic        wb_is_int_o;
  logic [4:0]  wb_status_o;
  logic [7:0]  wb_tag_o;
  logic        wb_mask_o;
  logic [4:0]  fflags_o;
  logic        fflags_clr_i;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;

  fpnew_noncomp_writeback #(.Width(32), .Flen(64), .TagWidth(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .result_i(result_i), .status_i(status_i), .extension_bit_i(extension_bit_i),
    .class_mask_i(class_mask_i), .is_class_i(is_class_i), .tag_i(tag_i), .mask_i(mask_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .wb_data_o(wb_data_o), .wb_is_int_o(wb_is_int_o), .wb_status_o(wb_status_o),
    .wb_tag_o(wb_tag_o), .wb_mask_o(wb_mask_o), .fflags_o(fflags_o),
    .fflags_clr_i(fflags_clr_i), .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] res, input logic [4:0] st,
                        input logic ext, input logic cls, input logic [9:0] cm,
                        input logic [7:0] tg, input logic m);
    in_valid_i = v; result_i = res; status_i = st; extension_bit_i = ext;
    is_class_i = cls; class_mask_i = cm; tag_i = tg; mask_i = m;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0; fflags_clr_i = 1'b0;
    set_in(1'b0, 32'h0, 5'h0, 1'b0, 1'b0, 10'h0, 8'h0, 1'b1);
    #12;
    n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_o); end
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    n_cmp++; if (fflags_o !== 5'b0) begin n_err++; $display("FAIL reset_fflags got=%b exp=00000", fflags_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    cycle();
  endtask

  task automatic test_nanbox();
    set_in(1'b1, 32'h3F800000, 5'h0, 1'b1, 1'b0, 10'h0, 8'h05, 1'b1);
    out_ready_i = 1'b0;
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL nanbox_no_bypass got=%b exp=0", out_valid_o); end
    cycle();
    in_valid_i = 1'b0;
    n_cmp++; if (out_valid_o !== 1'b1) begin n_err++; $display("FAIL nanbox_valid got=%b exp=1", out_valid_o); end
    n_cmp++; if (wb_data_o !== 64'hFFFFFFFF_3F800000) begin n_err++; $display("FAIL nanbox_data got=%h exp=ffffffff3f800000", wb_data_o); end
    n_cmp++; if (wb_is_int_o !== 1'b0) begin n_err++; $display("FAIL nanbox_is_int got=%b exp=0", wb_is_int_o); end
    n_cmp++; if (wb_tag_o !== 8'h05) begin n_err++; $display("FAIL nanbox_tag got=%h exp=05", wb_tag_o); end
    out_ready_i = 1'b1;
    cycle();
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL nanbox_drain got=%b exp=0", out_valid_o); end
  endtask

  task automatic test_class_and_int();
    out_ready_i = 1'b0;
    set_in(1'b1, 32'hDEADBEEF, 5'h0, 1'b1, 1'b1, 10'h040, 8'h11, 1'b1);
    cycle();
    set_in(1'b1, 32'h80000001, 5'h0, 1'b0, 1'b0, 10'h0, 8'h12, 1'b1);
    n_cmp++; if (wb_data_o !== 64'h0000000000000040) begin n_err++; $display("FAIL class_data got=%h exp=0000000000000040", wb_data_o); end
    n_cmp++; if (wb_is_int_o !== 1'b1) begin n_err++; $display("FAIL class_is_int got=%b exp=1", wb_is_int_o); end
    cycle();
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    cycle();
    out_ready_i = 1'b0;
    n_cmp++; if (wb_data_o !== 64'h0000000080000001) begin n_err++; $display("FAIL int_data got=%h exp=0000000080000001", wb_data_o); end
    n_cmp++; if (wb_is_int_o !== 1'b1) begin n_err++; $display("FAIL int_is_int got=%b exp=1", wb_is_int_o); end
    n_cmp++; if (wb_tag_o !== 8'h12) begin n_err++; $display("FAIL int_tag got=%h exp=12", wb_tag_o); end
    out_ready_i = 1'b1;
    cycle();
    out_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready_i = 1'b0;
    set_in(1'b1, 32'h1, 5'h0, 1'b1, 1'b0, 10'h0, 8'd1, 1'b1);
    cycle();
    tag_i = 8'd2; result_i = 32'h2;
    cycle();
    tag_i = 8'd3; result_i = 32'h3;
    cycle();
    n_cmp++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_full_ready got=%b exp=0", in_ready_o); end
    n_cmp++; if (wb_tag_o !== 8'd1) begin n_err++; $display("FAIL bp_head_tag got=%0d exp=1", wb_tag_o); end
    cycle();
    n_cmp++; if (wb_data_o !== 64'hFFFFFFFF_00000001) begin n_err++; $display("FAIL bp_stable_data got=%h exp=ffffffff00000001", wb_data_o); end
    n_cmp++; if (wb_tag_o !== 8'd1) begin n_err++; $display("FAIL bp_stable_tag got=%0d exp=1", wb_tag_o); end
    out_ready_i = 1'b1;
    cycle();
    n_cmp++; if (wb_tag_o !== 8'd2) begin n_err++; $display("FAIL bp_second_tag got=%0d exp=2", wb_tag_o); end
    n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL bp_ready_after_pop got=%b exp=1", in_ready_o); end
    cycle();
    in_valid_i = 1'b0;
    n_cmp++; if (wb_tag_o !== 8'd3) begin n_err++; $display("FAIL bp_third_tag got=%0d exp=3", wb_tag_o); end
    n_cmp++; if (out_valid_o !== 1'b1) begin n_err++; $display("FAIL bp_third_valid got=%b exp=1", out_valid_o); end
    cycle();
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL bp_drained got=%b exp=0", out_valid_o); end
  endtask

  task automatic test_fflags();
    out_ready_i = 1'b1;
    set_in(1'b1, 32'h0, 5'b10000, 1'b1, 1'b0, 10'h0, 8'h20, 1'b1);
    cycle();
    in_valid_i = 1'b0;
    cycle();
    n_cmp++; if (fflags_o !== 5'b10000) begin n_err++; $display("FAIL ff_nv got=%b exp=10000", fflags_o); end
    set_in(1'b1, 32'h0, 5'b00001, 1'b1, 1'b0, 10'h0, 8'h21, 1'b0);
    cycle();
    in_valid_i = 1'b0;
    n_cmp++; if (wb_status_o !== 5'b0) begin n_err++; $display("FAIL ff_masked_status got=%b exp=00000", wb_status_o); end
    n_cmp++; if (wb_mask_o !== 1'b0) begin n_err++; $display("FAIL ff_masked_bit got=%b exp=0", wb_mask_o); end
    cycle();
    n_cmp++; if (fflags_o !== 5'b10000) begin n_err++; $display("FAIL ff_masked_pop got=%b exp=10000", fflags_o); end
    set_in(1'b1, 32'h0, 5'b00001, 1'b1, 1'b0, 10'h0, 8'h22, 1'b1);
    cycle();
    in_valid_i = 1'b0;
    fflags_clr_i = 1'b1;
    cycle();
    fflags_clr_i = 1'b0;
    n_cmp++; if (fflags_o !== 5'b00001) begin n_err++; $display("FAIL ff_clr_pop got=%b exp=00001", fflags_o); end
    fflags_clr_i = 1'b1;
    cycle();
    fflags_clr_i = 1'b0;
    n_cmp++; if (fflags_o !== 5'b0) begin n_err++; $display("FAIL ff_clr_only got=%b exp=00000", fflags_o); end
  endtask

  task automatic test_flush();
    out_ready_i = 1'b1;
    set_in(1'b1, 32'h0, 5'b00100, 1'b1, 1'b0, 10'h0, 8'h30, 1'b1);
    cycle();
    in_valid_i = 1'b0;
    cycle();
    out_ready_i = 1'b0;
    set_in(1'b1, 32'h0, 5'b01000, 1'b1, 1'b0, 10'h0, 8'h31, 1'b1);
    cycle();
    tag_i = 8'h32;
    cycle();
    n_cmp++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_pre_full got=%b exp=0", in_ready_o); end
    set_in(1'b1, 32'h0, 5'b00010, 1'b1, 1'b0, 10'h0, 8'h33, 1'b1);
    flush_i = 1'b1;
    out_ready_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_valid got=%b exp=0", out_valid_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL flush_busy got=%b exp=0", busy_o); end
    n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL flush_ready got=%b exp=1", in_ready_o); end
    n_cmp++; if (fflags_o !== 5'b00100) begin n_err++; $display("FAIL flush_fflags got=%b exp=00100", fflags_o); end
    cycle();
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_discard got=%b exp=0", out_valid_o); end
  endtask

  task automatic test_async_reset();
    out_ready_i = 1'b0;
    set_in(1'b1, 32'h0, 5'h0, 1'b1, 1'b0, 10'h0, 8'h40, 1'b1);
    cycle();
    in_valid_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL areset_pre_busy got=%b exp=1", busy_o); end
    #2 rst_ni = 1'b0;
    #1;
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL areset_valid got=%b exp=0", out_valid_o); end
    n_cmp++; if (fflags_o !== 5'b0) begin n_err++; $display("FAIL areset_fflags got=%b exp=00000", fflags_o); end
    n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL areset_ready got=%b exp=1", in_ready_o); end
    #1 rst_ni = 1'b1;
    cycle();
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL areset_after got=%b exp=0", out_valid_o); end
  endtask

  initial begin
    test_reset();
    test_nanbox();
    test_class_and_int();
    test_back_to_back();
    test_fflags();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
